// File: rtl/seq_pkg.sv
// Shared types for the job sequencer: FSM state encoding and the on/off enable type.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      DONE    = 2'd2
   } state_t;

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } toggle_t;

endpackage

// File: rtl/seq_down_counter.sv
// Run-length down counter for the job sequencer: clear, load, decrement or hold, plus a zero flag.
module seq_down_counter #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             dec,
   output logic [LEN_W-1:0] count,
   output logic             zero
);

   // Clear wins over load, load wins over decrement.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec) begin
         count <= count - LEN_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/job_sequencer.sv
// Job sequencer: accepts a length-tagged job, runs it for len enabled cycles, then pulses done.
// Defining JOB_SEQUENCER_ABORT_EN adds an abort input and a one-cycle aborted output.
module job_sequencer
   import seq_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  toggle_t          enable,
   input  logic             req_valid,
   input  logic [LEN_W-1:0] req_len,
   output logic             req_ready,
   output state_t           state_o,
   output logic [LEN_W-1:0] count_o,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] done_len,
   output logic [CNT_W-1:0] job_cnt
`ifdef JOB_SEQUENCER_ABORT_EN
   ,
   input  logic             abort,
   output logic             aborted
`endif
);

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_value;
   logic [CNT_W-1:0] job_cnt_q;
   logic             accept;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_clr;
   logic             cnt_zero;

   // Gating with rst_n keeps ready low for the whole reset window.
   assign req_ready = rst_n && (state_q == IDLE) && (enable == ON);
   assign accept    = req_valid && req_ready;

   seq_down_counter #(
      .LEN_W(LEN_W)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (req_len),
      .dec      (cnt_dec),
      .count    (cnt_value),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_load = 1'b1;
               state_d  = (req_len == '0) ? DONE : RUNNING;
            end
         end
         RUNNING: begin
`ifdef JOB_SEQUENCER_ABORT_EN
            if (abort) begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end else
`endif
            if ((enable == ON) && !cnt_zero) begin
               cnt_dec = 1'b1;
               if (cnt_value == LEN_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         job_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            len_q <= req_len;
         end
         if (state_q == DONE) begin
            job_cnt_q <= job_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef JOB_SEQUENCER_ABORT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aborted <= 1'b0;
      end else begin
         aborted <= abort && (state_q == RUNNING);
      end
   end
`endif

   assign state_o  = state_q;
   assign count_o  = cnt_value;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign done_len = done ? len_q : '0;
   assign job_cnt  = job_cnt_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: directed scenarios plus randomized traffic against a job-level model.
`timescale 1ns/1ps
module tb_job_sequencer;
   import seq_pkg::*;

   localparam int LEN_W = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   toggle_t          enable;
   logic             req_valid;
   logic [LEN_W-1:0] req_len;
   logic             req_ready;
   state_t           state_o;
   logic [LEN_W-1:0] count_o;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] done_len;
   logic [CNT_W-1:0] job_cnt;
`ifdef JOB_SEQUENCER_ABORT_EN
   logic             abort;
   logic             aborted;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model: job phase, remaining enabled run cycles, captured length, jobs completed.
   state_t m_state = IDLE;
   int     m_rem = 0;
   int     m_len = 0;
   int     m_jobs = 0;
   int     m_aborted = 0;

   always #5 clk = ~clk;

   job_sequencer #(
      .LEN_W(LEN_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .req_valid (req_valid),
      .req_len   (req_len),
      .req_ready (req_ready),
      .state_o   (state_o),
      .count_o   (count_o),
      .busy      (busy),
      .done      (done),
      .done_len  (done_len),
      .job_cnt   (job_cnt)
`ifdef JOB_SEQUENCER_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   task automatic model_edge();
      logic ab;
      ab = 1'b0;
`ifdef JOB_SEQUENCER_ABORT_EN
      ab = abort;
`endif
      m_aborted = 0;
      if (!rst_n) begin
         m_state = IDLE; m_rem = 0; m_len = 0; m_jobs = 0;
      end else if (m_state == IDLE) begin
         if (req_valid && enable == ON) begin
            m_len = int'(req_len);
            m_rem = int'(req_len);
            m_state = (req_len == 0) ? DONE : RUNNING;
         end
      end else if (m_state == RUNNING) begin
         if (ab) begin
            m_state = IDLE; m_rem = 0; m_aborted = 1;
         end else if (enable == ON) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_state = DONE;
         end
      end else begin
         m_state = IDLE;
         m_jobs = m_jobs + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = ON; req_valid = 1'b1; req_len = 8'd5;
`ifdef JOB_SEQUENCER_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      checks++;
      if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_early got=%0b exp=0", req_ready); end
      tick(); tick();
      checks++;
      if (state_o !== IDLE) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=%0d", state_o, IDLE); end
      checks++;
      if (count_o !== 8'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count_o); end
      checks++;
      if (done !== 1'b0 || done_len !== 8'd0) begin failures++; $display("[TB] FAIL reset_done got=%0b/%0d exp=0/0", done, done_len); end
      checks++;
      if (job_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_job_cnt got=%0d exp=0", job_cnt); end
      checks++;
      if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=0", req_ready); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
      rst_n = 1'b1; req_valid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%0b exp=1", req_ready); end
   endtask

   task automatic test_reset_mid_job();
      int guard;
      enable = ON; req_valid = 1'b1; req_len = 8'd5;
      tick();
      req_valid = 1'b0;
      guard = 0;
      while (count_o !== 8'd2 && guard < 10) begin tick(); guard++; end
      checks++;
      if (state_o !== RUNNING || count_o !== 8'd2) begin failures++; $display("[TB] FAIL midjob_setup got=%0d/%0d exp=%0d/2", state_o, count_o, RUNNING); end
      rst_n = 1'b0;
      tick();
      checks++;
      if (state_o !== IDLE || count_o !== 8'd0) begin failures++; $display("[TB] FAIL midjob_reset_state got=%0d/%0d exp=%0d/0", state_o, count_o, IDLE); end
      checks++;
      if (done !== 1'b0 || job_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midjob_reset_done got=%0b/%0d exp=0/0", done, job_cnt); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || job_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midjob_after got=%0b/%0b/%0d exp=0/0/0", done, busy, job_cnt); end
   endtask

   task automatic test_single_job();
      state_t exp_s[5] = '{RUNNING, RUNNING, RUNNING, DONE, IDLE};
      int     exp_c[5] = '{3, 2, 1, 0, 0};
      int     base;
      base = m_jobs;
      enable = ON; req_valid = 1'b1; req_len = 8'd3;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (state_o !== exp_s[k] || count_o !== LEN_W'(exp_c[k])) begin
            failures++; $display("[TB] FAIL single_cycle%0d got=%0d/%0d exp=%0d/%0d", k + 1, state_o, count_o, exp_s[k], exp_c[k]);
         end
         checks++;
         if (done !== (exp_s[k] == DONE)) begin failures++; $display("[TB] FAIL single_done%0d got=%0b exp=%0b", k + 1, done, exp_s[k] == DONE); end
         if (k == 3) begin
            checks++;
            if (done_len !== 8'd3) begin failures++; $display("[TB] FAIL single_done_len got=%0d exp=3", done_len); end
         end
         if (k < 4) tick();
      end
      checks++;
      if (job_cnt !== CNT_W'(base + 1)) begin failures++; $display("[TB] FAIL single_job_cnt got=%0d exp=%0d", job_cnt, base + 1); end
   endtask

   task automatic test_zero_len();
      int base;
      base = m_jobs;
      enable = ON; req_valid = 1'b1; req_len = 8'd0;
      tick();
      req_valid = 1'b0;
      checks++;
      if (state_o !== DONE || done !== 1'b1 || done_len !== 8'd0 || count_o !== 8'd0) begin
         failures++; $display("[TB] FAIL zero_len_done got=%0d/%0b/%0d/%0d exp=%0d/1/0/0", state_o, done, done_len, count_o, DONE);
      end
      tick();
      checks++;
      if (state_o !== IDLE || done !== 1'b0 || job_cnt !== CNT_W'(base + 1)) begin
         failures++; $display("[TB] FAIL zero_len_after got=%0d/%0b/%0d exp=%0d/0/%0d", state_o, done, job_cnt, IDLE, base + 1);
      end
   endtask

   task automatic test_enable_pause();
      int base;
      int done_at;
      base = m_jobs;
      done_at = -1;
      enable = ON; req_valid = 1'b1; req_len = 8'd4;
      tick();
      req_len = 8'd7;
      for (int n = 1; n <= 12; n++) begin
         if (done === 1'b1 && done_at < 0) begin
            done_at = n;
            req_valid = 1'b0;
            checks++;
            if (done_len !== 8'd4) begin failures++; $display("[TB] FAIL pause_done_len got=%0d exp=4", done_len); end
         end
         enable = (n == 2 || n == 3) ? OFF : ON;
         #1;
         if (state_o == RUNNING) begin
            checks++;
            if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL pause_ready_running cycle=%0d got=%0b exp=0", n, req_ready); end
         end
         tick();
      end
      enable = ON;
      checks++;
      if (done_at != 7) begin failures++; $display("[TB] FAIL pause_done_cycle got=%0d exp=7", done_at); end
      checks++;
      if (state_o !== IDLE || job_cnt !== CNT_W'(base + 1)) begin
         failures++; $display("[TB] FAIL pause_after got=%0d/%0d exp=%0d/%0d", state_o, job_cnt, IDLE, base + 1);
      end
   endtask

   task automatic test_back_to_back();
      enable = ON; req_valid = 1'b1; req_len = 8'd2;
      tick(); tick(); tick();
      req_len = 8'd1;
      #1;
      checks++;
      if (state_o !== DONE || req_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_ready got=%0d/%0b exp=%0d/0", state_o, req_ready, DONE); end
      tick();
      checks++;
      if (state_o !== IDLE || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle got=%0d/%0b exp=%0d/1", state_o, req_ready, IDLE); end
      tick();
      req_valid = 1'b0;
      checks++;
      if (state_o !== RUNNING || count_o !== 8'd1) begin failures++; $display("[TB] FAIL b2b_second got=%0d/%0d exp=%0d/1", state_o, count_o, RUNNING); end
      tick();
      checks++;
      if (done !== 1'b1 || done_len !== 8'd1) begin failures++; $display("[TB] FAIL b2b_second_done got=%0b/%0d exp=1/1", done, done_len); end
      tick();
   endtask

`ifdef JOB_SEQUENCER_ABORT_EN
   task automatic test_abort();
      int base;
      base = m_jobs;
      enable = ON; req_valid = 1'b1; req_len = 8'd3;
      tick();
      req_valid = 1'b0;
      tick(); tick();
      checks++;
      if (count_o !== 8'd1) begin failures++; $display("[TB] FAIL abort_setup got=%0d exp=1", count_o); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (aborted !== 1'b1 || state_o !== IDLE || count_o !== 8'd0 || done !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_pulse got=%0b/%0d/%0d/%0b exp=1/%0d/0/0", aborted, state_o, count_o, done, IDLE);
      end
      tick();
      checks++;
      if (aborted !== 1'b0 || done !== 1'b0 || job_cnt !== CNT_W'(base)) begin
         failures++; $display("[TB] FAIL abort_after got=%0b/%0b/%0d exp=0/0/%0d", aborted, done, job_cnt, base);
      end
   endtask
`endif

   task automatic test_random();
      logic exp_ready;
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 49) != 0);
         enable    = ($urandom_range(0, 3) != 0) ? ON : OFF;
         req_valid = $urandom_range(0, 1) != 0;
         req_len   = LEN_W'($urandom_range(0, 6));
`ifdef JOB_SEQUENCER_ABORT_EN
         abort     = ($urandom_range(0, 15) == 0);
`endif
         #1;
         exp_ready = rst_n && (m_state == IDLE) && (enable == ON);
         checks++;
         if (req_ready !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready i=%0d got=%0b exp=%0b", i, req_ready, exp_ready); end
         tick();
         checks++;
         if (state_o !== m_state || count_o !== LEN_W'(m_rem)) begin
            failures++; $display("[TB] FAIL rand_state i=%0d got=%0d/%0d exp=%0d/%0d", i, state_o, count_o, m_state, m_rem);
         end
         checks++;
         if (busy !== (m_state != IDLE) || done !== (m_state == DONE)) begin
            failures++; $display("[TB] FAIL rand_flags i=%0d got=%0b/%0b exp=%0b/%0b", i, busy, done, m_state != IDLE, m_state == DONE);
         end
         checks++;
         if (done_len !== ((m_state == DONE) ? LEN_W'(m_len) : 8'd0)) begin
            failures++; $display("[TB] FAIL rand_done_len i=%0d got=%0d exp=%0d", i, done_len, (m_state == DONE) ? m_len : 0);
         end
         checks++;
         if (job_cnt !== CNT_W'(m_jobs)) begin failures++; $display("[TB] FAIL rand_job_cnt i=%0d got=%0d exp=%0d", i, job_cnt, CNT_W'(m_jobs)); end
`ifdef JOB_SEQUENCER_ABORT_EN
         checks++;
         if (aborted !== (m_aborted != 0)) begin failures++; $display("[TB] FAIL rand_aborted i=%0d got=%0b exp=%0b", i, aborted, m_aborted != 0); end
`endif
      end
`ifdef JOB_SEQUENCER_ABORT_EN
      abort = 1'b0;
`endif
   endtask

   task automatic test_wrap();
      int guard;
      rst_n = 1'b0; req_valid = 1'b0; enable = ON;
      tick();
      rst_n = 1'b1; req_valid = 1'b1; req_len = 8'd0;
      guard = 0;
      while (m_jobs < 255 && guard < 2000) begin tick(); guard++; end
      checks++;
      if (job_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_all_ones got=%0d exp=255", job_cnt); end
      while (m_jobs < 256 && guard < 2000) begin tick(); guard++; end
      req_valid = 1'b0;
      checks++;
      if (job_cnt !== 8'd0 || guard >= 2000) begin failures++; $display("[TB] FAIL wrap_to_zero got=%0d exp=0 guard=%0d", job_cnt, guard); end
   endtask

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog timeout reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_reset_mid_job();
      test_single_job();
      test_zero_len();
      test_enable_pause();
      test_back_to_back();
`ifdef JOB_SEQUENCER_ABORT_EN
      test_abort();
`endif
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
